mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; the operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ALUSrcA  input  32  operand A (dividend / multiplicand), same operand bus that feeds the ALU.
REQ-005 ALUSrcB  input  32  operand B (divisor / multiplier).
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  1  0 = MULT (signed), 1 = DIV (signed); sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 HI  output  32  MULT: product[63:32]; DIV: remainder.
REQ-011 LO  output  32  MULT: product[31:0]; DIV: quotient.
REQ-012 DIV_ZERO  output  1  divide-by-zero flag.

Function
REQ-013 States SHALL be IDLE, RUN, FIX, DONE; IDLE->RUN on start, RUN->FIX after 32 iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-014 On an accepted start, operands SHALL be latched, converted to magnitudes, and the sign flags stored; later changes on ALUSrcA/ALUSrcB SHALL have no effect.
REQ-015 RUN SHALL perform one shift-add (MULT) or one restoring shift-subtract (DIV) step per cycle, using an iteration counter running 0..31.
REQ-016 FIX SHALL apply the signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
REQ-017 HI/LO SHALL update only in the DONE cycle and hold otherwise; done = 1 only in DONE.
REQ-018 Latency: done SHALL be high exactly 34 rising edges after the edge that samples start.
REQ-019 start while busy, or in the DONE cycle, SHALL be ignored (no queueing).
REQ-020 DIV with ALUSrcB = 0: skip RUN/FIX and go IDLE->DONE; done SHALL pulse 1 edge after the start edge; HI/LO SHALL be unchanged; DIV_ZERO = 1.
REQ-021 DIV_ZERO SHALL be cleared by the next accepted start.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0 (magnitude arithmetic wraps, no trap).
REQ-023 MULT SHALL produce the exact 64-bit two's-complement product for all inputs, including 0x80000000 * 0x80000000 = 0x4000000000000000.

Reset
REQ-024 reset SHALL force IDLE, counter = 0, HI = LO = 0, busy = done = DIV_ZERO = 0, and clear internal operand registers.
REQ-025 reset asserted mid-operation SHALL abort it; no done pulse SHALL follow, and a start sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro MULT_DIV_UNIT_DIV_EN: when defined, DIV SHALL be supported as specified.
REQ-027 When it is not defined, the divider datapath SHALL be omitted, a start with op = 1 SHALL go IDLE->DONE with HI/LO unchanged and DIV_ZERO = 1, and MULT SHALL be unaffected.

Structure
REQ-028 Package multdiv_pkg SHALL hold the op encodings (OP_MULT, OP_DIV), the state enum, and the constant ITERATIONS = 32.
REQ-029 Sub-module multdiv_step SHALL hold the combinational single-iteration add/subtract-and-shift; the FSM, counter and registers SHALL stay in mult_div_unit.

Verification
REQ-030 MULT 0x00000007 * 0xFFFFFFFD -> done at edge +34, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-031 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, DIV_ZERO = 0.
REQ-032 DIV 0x00000010 / 0 -> done at edge +1, HI/LO keep their prior values, DIV_ZERO = 1; the next MULT start clears DIV_ZERO.
REQ-033 start pulsed again at edge +10 of a MULT, with operands changed -> ignored; result matches the original operands, single done.
REQ-034 reset at edge +20 of a DIV -> no done, all outputs 0 on the next cycle; a new start afterwards completes normally.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000; build without MULT_DIV_UNIT_DIV_EN -> DIV_ZERO = 1, done at edge +1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings, state enum and helpers for the multiply/divide unit
package multdiv_pkg;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;
  localparam int   ITERATIONS = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the issuing stage and the multiply/divide unit
interface mult_div_unit_if;
  logic [31:0] ALUSrcA;
  logic [31:0] ALUSrcB;
  logic        start;
  logic        op;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DIV_ZERO;

  modport master (
    output ALUSrcA, ALUSrcB, start, op,
    input  busy, done, HI, LO, DIV_ZERO
  );

  modport slave (
    input  ALUSrcA, ALUSrcB, start, op,
    output busy, done, HI, LO, DIV_ZERO
  );
endinterface

// File: rtl/multdiv_step.sv
// rtl/multdiv_step.sv - one combinational shift-add (MULT) or restoring shift-subtract (DIV) iteration
// Divider half is present only when MULT_DIV_UNIT_DIV_EN is defined.
module multdiv_step
  import multdiv_pkg::*;
(
  input  logic        op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] m,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [32:0] sum;
`ifdef MULT_DIV_UNIT_DIV_EN
  logic [32:0] shifted;
  logic [32:0] diff;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  always_comb begin
    // MULT: lo holds the remaining multiplier bits, product shifts in from the top
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    hi_next = sum[32:1];
    lo_next = {sum[0], lo[31:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
    // DIV: partial remainder stays below m, so the 33-bit difference never overflows
    shifted = {hi, lo[31]};
    diff    = shifted - {1'b0, m};
    if (op == OP_DIV) begin
      if (!diff[32]) begin
        hi_next = diff[31:0];
        lo_next = {lo[30:0], 1'b1};
      end else begin
        hi_next = shifted[31:0];
        lo_next = {lo[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 multiply / 32/32 divide with HI/LO results
// Divide support is compiled in only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit
  import multdiv_pkg::*;
(
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        op_q;
  logic        sa;
  logic        sb;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] mag_m;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod_mag;
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero_req;

  assign a_mag    = abs32(bus.ALUSrcA);
  assign b_mag    = abs32(bus.ALUSrcB);
  assign prod_mag = {acc_hi, acc_lo};
  assign prod_fix = (sa ^ sb) ? (~prod_mag + 64'd1) : prod_mag;

`ifdef MULT_DIV_UNIT_DIV_EN
  assign div_zero_req = (bus.op == OP_DIV) && (bus.ALUSrcB == 32'd0);
  // Remainder follows the dividend sign, quotient follows sA^sB
  assign res_hi = (op_q == OP_DIV) ? (sa ? (~acc_hi + 32'd1) : acc_hi) : prod_fix[63:32];
  assign res_lo = (op_q == OP_DIV) ? ((sa ^ sb) ? (~acc_lo + 32'd1) : acc_lo) : prod_fix[31:0];
`else
  assign div_zero_req = (bus.op == OP_DIV);
  assign res_hi       = prod_fix[63:32];
  assign res_lo       = prod_fix[31:0];
`endif

  multdiv_step u_step (
    .op      (op_q),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .m       (mag_m),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op_q   <= OP_MULT;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      mag_m  <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sa     <= bus.ALUSrcA[31];
            sb     <= bus.ALUSrcB[31];
            acc_hi <= 32'd0;
            cnt    <= 5'd0;
            dz_q   <= 1'b0;
            if (bus.op == OP_DIV) begin
              acc_lo <= a_mag;
              mag_m  <= b_mag;
            end else begin
              acc_lo <= b_mag;
              mag_m  <= a_mag;
            end
            if (div_zero_req) begin
              dz_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.DIV_ZERO = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed checks of mult_div_unit against a signed-arithmetic model
module tb_mult_div_unit;

  logic clk;
  logic reset;
  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_compared;
  int          n_mismatched;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_dz;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  // inject_at > 0: re-pulse start with other operands while busy; < 0: pulse start in the DONE cycle
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input string tag);
    longint sa_l;
    longint sb_l;
    longint p;
    longint q;
    longint r;
    logic   is_dz;
    int     exp_lat;
    int     k;

    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
`ifdef MULT_DIV_UNIT_DIV_EN
    is_dz = (o == 1'b1) && (b == 32'd0);
`else
    is_dz = (o == 1'b1);
`endif
    exp_dz = is_dz;
    if (is_dz) begin
      exp_lat = 1;
    end else if (o == 1'b0) begin
      p = sa_l * sb_l;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_lat = 34;
    end else begin
      q = sa_l / sb_l;
      r = sa_l % sb_l;
      exp_hi = r[31:0];
      exp_lo = q[31:0];
      exp_lat = 34;
    end

    @(negedge clk);
    bus.op = o;
    bus.ALUSrcA = a;
    bus.ALUSrcB = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ALUSrcA = $urandom;
    bus.ALUSrcB = $urandom;
    k = 1;
    check_eq({tag, ":busy"}, bus.busy, !is_dz);
    while (!bus.done && k < 60) begin
      @(negedge clk);
      k++;
      if (inject_at > 0 && k == inject_at) begin
        bus.start = 1'b1;
        bus.op = 1'b0;
        bus.ALUSrcA = 32'h1234_5678;
        bus.ALUSrcB = 32'h0000_0003;
      end else begin
        bus.start = 1'b0;
      end
    end
    check_eq({tag, ":latency"}, k, exp_lat);
    check_eq({tag, ":HI"}, bus.HI, exp_hi);
    check_eq({tag, ":LO"}, bus.LO, exp_lo);
    check_eq({tag, ":DIV_ZERO"}, bus.DIV_ZERO, exp_dz);
    check_eq({tag, ":busy_done"}, bus.busy, 1'b0);
    if (inject_at < 0) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, ":done_pulse"}, bus.done, 1'b0);
    if (inject_at != 0) watch_no_done({tag, ":no_second_done"}, 40);
  endtask

  initial begin
    int k;
    logic o;
    logic [31:0] a;
    logic [31:0] b;

    n_compared = 0;
    n_mismatched = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    exp_dz = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.ALUSrcA = 32'd0;
    bus.ALUSrcB = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst:HI", bus.HI, 32'd0);
    check_eq("rst:LO", bus.LO, 32'd0);
    check_eq("rst:busy", bus.busy, 1'b0);
    check_eq("rst:done", bus.done, 1'b0);
    check_eq("rst:DIV_ZERO", bus.DIV_ZERO, 1'b0);
    reset = 1'b0;

    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, "mult_7x-3");
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_-7/2");
    run_op(1'b1, 32'h0000_0010, 32'h0000_0000, 0, "div_by_zero");
    run_op(1'b0, 32'h0000_0005, 32'h0000_0006, 0, "mult_clears_dz");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min/-1");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min*min");
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10, "start_while_busy");
    run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -1, "start_in_done");

    // Reset mid-operation, with start asserted in the reset cycle
    @(negedge clk);
`ifdef MULT_DIV_UNIT_DIV_EN
    bus.op = 1'b1;
`else
    bus.op = 1'b0;
`endif
    bus.ALUSrcA = 32'h0001_0000;
    bus.ALUSrcB = 32'h0000_0007;
    bus.start = 1'b1;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (bus.done) check_eq("abort:early_done", bus.done, 1'b0);
    end
    reset = 1'b1;
    bus.start = 1'b1;
    bus.op = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    exp_dz = 1'b0;
    check_eq("abort:HI", bus.HI, 32'd0);
    check_eq("abort:LO", bus.LO, 32'd0);
    check_eq("abort:busy", bus.busy, 1'b0);
    check_eq("abort:done", bus.done, 1'b0);
    check_eq("abort:DIV_ZERO", bus.DIV_ZERO, 1'b0);
    watch_no_done("abort:no_done", 40);
    run_op(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 0, "after_abort");

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($signed(8'($urandom)));
      run_op(o, a, b, 0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
